// File: rtl/debounce_filter_if.sv
// Level/pulse bundle between the input synchronizer and the debounce filter.
// The auto-repeat pulse is carried as repeat_pulse because "repeat" is a reserved word.
interface debounce_filter_if #(
  parameter int WIDTH = 1
) ();
  logic [WIDTH-1:0] i;
  logic [WIDTH-1:0] o;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] repeat_pulse;

  modport master (output i, input o, rise, fall, repeat_pulse);
  modport slave  (input i, output o, rise, fall, repeat_pulse);
endinterface

// File: rtl/debounce_filter.sv
// Per-bit debounce filter with registered rise/fall pulses.
// Optional auto-repeat pulses are enabled with `define DEBOUNCE_AUTOREPEAT_EN.
module debounce_filter #(
  parameter int          WIDTH         = 1,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic        RESET_LEVEL   = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 500000,
  parameter int unsigned REPEAT_RATE   = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  debounce_filter_if.slave bus
);
  localparam int            CW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] flip;

  // A bit flips on the edge where a mismatch reaches terminal count.
  always_comb begin
    flip = '0;
    for (int b = 0; b < WIDTH; b++) begin
      flip[b] = (bus.i[b] != level[b]) && (cnt[b] == TERM);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every bit samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level  <= {WIDTH{RESET_LEVEL}};
      rise_q <= '0;
      fall_q <= '0;
      // NOTE: the counter array is a handful of flops, not a RAM, so it is reset explicitly.
      for (int b = 0; b < WIDTH; b++) begin
        cnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        rise_q[b] <= 1'b0;
        fall_q[b] <= 1'b0;
        if (bus.i[b] == level[b]) begin
          cnt[b] <= '0;
        end else if (flip[b]) begin
          level[b]  <= bus.i[b];
          cnt[b]    <= '0;
          rise_q[b] <= bus.i[b];
          fall_q[b] <= ~bus.i[b];
        end else begin
          cnt[b] <= cnt[b] + CW'(1);
        end
      end
    end
  end

  assign bus.o    = level;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned   RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int            RW         = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LOAD  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0]    rcnt [WIDTH];
  logic [WIDTH-1:0] armed;
  logic [WIDTH-1:0] rpt_q;

  // Down-counter reloads on each pulse; armed only between a rise and the next fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed <= '0;
      rpt_q <= '0;
      for (int b = 0; b < WIDTH; b++) begin
        rcnt[b] <= '0;
      end
    end else begin
      for (int b = 0; b < WIDTH; b++) begin
        rpt_q[b] <= 1'b0;
        if (flip[b]) begin
          armed[b] <= bus.i[b];
          rpt_q[b] <= bus.i[b];
          rcnt[b]  <= bus.i[b] ? DELAY_LOAD : '0;
        end else if (armed[b]) begin
          if (rcnt[b] == '0) begin
            rpt_q[b] <= 1'b1;
            rcnt[b]  <= RATE_LOAD;
          end else begin
            rcnt[b] <= rcnt[b] - RW'(1);
          end
        end
      end
    end
  end

  assign bus.repeat_pulse = rpt_q;
`else
  assign bus.repeat_pulse = '0;
`endif
endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter: reset, latency, bounce, glitch, multi-bit and auto-repeat.
module tb_debounce_filter;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   rises;

  always #5 clk = ~clk;

  debounce_filter_if #(.WIDTH(2)) bus_a ();
  debounce_filter_if #(.WIDTH(1)) bus_b ();

  debounce_filter #(
    .WIDTH(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave)
  );

  debounce_filter #(
    .WIDTH(1), .STABLE_CYCLES(1), .RESET_LEVEL(1'b0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected repeat for k samples after the rise sample (REPEAT_DELAY=10, REPEAT_RATE=3).
  function automatic logic rep_exp(input int k);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    return (k == 0) || ((k >= 10) && (((k - 10) % 3) == 0));
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    logic seq [8];
    logic b1;

    // Reset held with a mismatching input: outputs stay at reset values.
    reset_n  = 1'b0;
    bus_a.i  = 2'b01;
    bus_b.i  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("rst_o",    32'(bus_a.o), 0);
      check("rst_rise", 32'(bus_a.rise), 0);
      check("rst_fall", 32'(bus_a.fall), 0);
    end

    // Two mismatching edges, then asynchronous reset discards the partial count.
    reset_n = 1'b1;
    tick();
    tick();
    check("mid_o", 32'(bus_a.o), 0);
    reset_n = 1'b0;
    #1;
    check("async_o",    32'(bus_a.o), 0);
    check("async_rise", 32'(bus_a.rise), 0);
    tick();
    reset_n = 1'b1;

    // Count restarts: o rises on the 4th edge after release.
    for (int e = 0; e < 3; e++) begin
      tick();
      check("lat_hold", 32'(bus_a.o[0]), 0);
    end
    tick();
    check("rise_o",    32'(bus_a.o[0]), 1);
    check("rise_p",    32'(bus_a.rise[0]), 1);
    check("rise_fall", 32'(bus_a.fall[0]), 0);
    check("rep_k0",    32'(bus_a.repeat_pulse[0]), 32'(rep_exp(0)));

    // Held high: single rise pulse, auto-repeat schedule; i drops before sample 36.
    for (int k = 1; k <= 38; k++) begin
      if (k == 36) bus_a.i[0] = 1'b0;
      tick();
      check("hold_o",    32'(bus_a.o[0]), 1);
      check("hold_rise", 32'(bus_a.rise[0]), 0);
      check("hold_rep",  32'(bus_a.repeat_pulse[0]), 32'(rep_exp(k)));
    end
    tick();
    check("fall_o",   32'(bus_a.o[0]), 0);
    check("fall_p",   32'(bus_a.fall[0]), 1);
    check("fall_r",   32'(bus_a.rise[0]), 0);
    check("fall_rep", 32'(bus_a.repeat_pulse[0]), 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("post_fall",  32'(bus_a.fall[0]), 0);
      check("post_rep",   32'(bus_a.repeat_pulse[0]), 0);
      check("post_o",     32'(bus_a.o[0]), 0);
    end

    // Bounce: 1,1,1,0 then 1 held; rise only at edge 7.
    seq   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rises = 0;
    for (int s = 0; s < 8; s++) begin
      bus_a.i[0] = seq[s];
      tick();
      rises += int'(bus_a.rise[0]);
      if (s < 7) check("bounce_hold", 32'(bus_a.o[0]), 0);
    end
    check("bounce_o",    32'(bus_a.o[0]), 1);
    check("bounce_rise", 32'(bus_a.rise[0]), 1);
    tick();
    rises += int'(bus_a.rise[0]);
    tick();
    rises += int'(bus_a.rise[0]);
    check("bounce_count", 32'(rises), 1);
    bus_a.i[0] = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("bounce_fall_o", 32'(bus_a.o[0]), 0);
    check("bounce_fall_p", 32'(bus_a.fall[0]), 1);

    // Single-cycle glitch: filtered at STABLE_CYCLES=4, passed through at 1.
    bus_a.i[0] = 1'b1;
    bus_b.i    = 1'b1;
    tick();
    check("glitch_b_o",    32'(bus_b.o), 1);
    check("glitch_b_rise", 32'(bus_b.rise), 1);
    check("glitch_b_fall", 32'(bus_b.fall), 0);
    check("glitch_a_o",    32'(bus_a.o[0]), 0);
    bus_a.i[0] = 1'b0;
    bus_b.i    = 1'b0;
    tick();
    check("glitch_b_o2",   32'(bus_b.o), 0);
    check("glitch_b_fall2",32'(bus_b.fall), 1);
    check("glitch_b_rise2",32'(bus_b.rise), 0);
    check("glitch_a_o2",   32'(bus_a.o[0]), 0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("glitch_a_o3",   32'(bus_a.o[0]), 0);
      check("glitch_a_rise", 32'(bus_a.rise[0]), 0);
    end
    check("glitch_b_fall3", 32'(bus_b.fall), 0);

    // Two bits: bit0 clean step, bit1 toggling every cycle never settles.
    for (int s = 0; s < 6; s++) begin
      b1 = ((s % 2) == 0);
      bus_a.i = {b1, 1'b1};
      tick();
      check("w2_o1",    32'(bus_a.o[1]), 0);
      check("w2_rise1", 32'(bus_a.rise[1]), 0);
      check("w2_fall1", 32'(bus_a.fall[1]), 0);
      check("w2_o0",    32'(bus_a.o[0]), 32'(s >= 3));
      check("w2_rise0", 32'(bus_a.rise[0]), 32'(s == 3));
    end

    check("b_rep", 32'(bus_b.repeat_pulse), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
